fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer that owns the program counter.
- Issues requests to instruction memory over a req/ack handshake and holds the fetched word in a one-entry output slot for decode.
- Applies decode stalls, branch/jump redirects, and a sticky misaligned-target fault.
- Sits between the instruction ROM/bus and the IF/ID stage.

---
 rtl/fetch_ctrl_pkg.sv | 23 ++
 rtl/fetch_ctrl.sv | 158 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage constants and state encoding.
package fetch_ctrl_pkg;

  localparam int unsigned InstAddrBus  = 32;
  localparam int unsigned InstBus      = 32;
  localparam logic [31:0] CpuResetAddr = 32'h0000_0000;
  localparam logic [31:0] NopInst      = 32'h0000_0013;
  localparam logic [31:0] Word         = 32'd4;
  localparam logic        RstnEnable   = 1'b0;

  typedef enum logic [1:0] {
    FetchIdle,
    FetchWait,
    FetchDrain,
    FetchHalt
  } fetch_state_e;

  // Instruction targets must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake and
// holds one fetched instruction for decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W     = InstAddrBus,
  parameter int unsigned       INST_W     = InstBus,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(CpuResetAddr),
  parameter logic [INST_W-1:0] NOP_INST   = INST_W'(NopInst)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              fault_o
);

  localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(Word);

  fetch_state_e      r_state, w_state_d;
  logic [ADDR_W-1:0] r_pc, w_pc_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic              r_req, w_req_d;
  logic              r_valid, w_valid_d;
  logic [INST_W-1:0] r_inst, w_inst_d;
  logic [ADDR_W-1:0] r_inst_pc, w_inst_pc_d;
  logic              r_fault, w_fault_d;
  logic              r_kill, w_kill_d;

  logic w_redir, w_redir_bad, w_redir_good;
  logic w_consume, w_slot_free, w_ack, w_fill;

  // Redirects are dead once a fault has been taken.
  assign w_redir      = redirect_i & ~r_fault & (r_state != FetchHalt);
  assign w_redir_bad  = w_redir & is_misaligned(redirect_pc_i[1:0]);
  assign w_redir_good = w_redir & ~w_redir_bad;
  assign w_consume    = r_valid & ~stall_i;
  assign w_slot_free  = ~r_valid | w_consume;
  assign w_ack        = imem_ack_i & r_req;
  assign w_fill       = (r_state == FetchWait) & w_ack & ~w_redir & w_slot_free;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RstnEnable) begin
      r_state <= FetchIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      FetchIdle: begin
        if (w_redir_bad) begin
          w_state_d = FetchHalt;
        end else if (w_redir_good || w_slot_free) begin
          w_state_d = FetchWait;
        end
      end
      FetchWait: begin
        if (w_redir_bad) begin
          w_state_d = w_ack ? FetchHalt : FetchDrain;
        end else if (w_redir_good) begin
          w_state_d = w_ack ? FetchWait : FetchDrain;
        end else if (w_fill) begin
          // Keep streaming only while decode is draining; a stalled decode
          // parks the fetcher so the next ack cannot meet a full slot.
          w_state_d = stall_i ? FetchIdle : FetchWait;
        end
        // Ack on a full, stalled slot is dropped and the same pc re-requested.
      end
      FetchDrain: begin
        if (w_ack) begin
          w_state_d = (r_kill || w_redir_bad) ? FetchHalt : FetchWait;
        end
      end
      FetchHalt: w_state_d = FetchHalt;
      default:   w_state_d = FetchIdle;
    endcase
  end

  // Output logic: request is registered from the next state.
  always_comb begin
    w_req_d = (w_state_d == FetchWait) || (w_state_d == FetchDrain);
  end

  // Datapath next-state: pc, request address, output slot and fault flags.
  always_comb begin
    w_pc_d      = r_pc;
    w_valid_d   = r_valid;
    w_inst_d    = r_inst;
    w_inst_pc_d = r_inst_pc;
    w_fault_d   = r_fault | w_redir_bad;
    w_kill_d    = r_kill | w_redir_bad;

    if (w_redir_good) begin
      w_pc_d = redirect_pc_i;
    end else if (w_fill) begin
      w_pc_d = r_pc + PcStep;
    end

    // A launched request latches its address; DRAIN keeps the old one.
    w_addr_d = (w_state_d == FetchWait) ? w_pc_d : r_addr;

    if (w_redir) begin
      w_valid_d = 1'b0;
      w_inst_d  = NOP_INST;
    end else if (w_fill) begin
      w_valid_d   = 1'b1;
      w_inst_d    = imem_rdata_i;
      w_inst_pc_d = r_pc;
    end else if (w_consume) begin
      w_valid_d = 1'b0;
      w_inst_d  = NOP_INST;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RstnEnable) begin
      r_pc      <= RESET_ADDR;
      r_addr    <= RESET_ADDR;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_inst    <= NOP_INST;
      r_inst_pc <= '0;
      r_fault   <= 1'b0;
      r_kill    <= 1'b0;
    end else begin
      r_pc      <= w_pc_d;
      r_addr    <= w_addr_d;
      r_req     <= w_req_d;
      r_valid   <= w_valid_d;
      r_inst    <= w_inst_d;
      r_inst_pc <= w_inst_pc_d;
      r_fault   <= w_fault_d;
      r_kill    <= w_kill_d;
    end
  end

  assign imem_req_o   = r_req;
  assign imem_addr_o  = r_addr;
  assign inst_valid_o = r_valid;
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_inst_pc;
  assign fault_o      = r_fault;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: latency-programmable memory model plus a
// queue of expected slot pcs popped whenever decode consumes the slot.
module tb_fetch_ctrl;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        fault_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned mem_lat  = 0;
  int unsigned mem_cnt  = 0;
  logic [31:0] exp_q[$];

  fetch_ctrl u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .fault_o      (fault_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
  endtask

  // One clock: observe at the falling edge, drive memory and decode inputs for
  // the next rising edge, and score the slot if decode takes it there.
  task automatic cycle(input logic s, input logic rd, input logic [31:0] rpc);
    logic [31:0] e;
    @(negedge clk_i);
    if (imem_req_o) begin
      if (mem_cnt >= mem_lat) begin
        imem_ack_i   = 1'b1;
        imem_rdata_i = mem_word(imem_addr_o);
        mem_cnt      = 0;
      end else begin
        imem_ack_i = 1'b0;
        mem_cnt++;
      end
    end else begin
      imem_ack_i = 1'b0;
      mem_cnt    = 0;
    end
    stall_i       = s;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    if (inst_valid_o && !s && !rd) begin
      if (exp_q.size() == 0) begin
        check_eq("slot_unexpected", 32'(inst_valid_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("slot_pc", inst_pc_o, e);
        check_eq("slot_inst", inst_o, mem_word(e));
      end
    end
  endtask

  // Async reset asserted mid-cycle, then released on a falling edge.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i         = 1'b0;
    imem_ack_i    = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    mem_cnt       = 0;
    #1;
    check_eq("rst_req", 32'(imem_req_o), 32'd0);
    check_eq("rst_valid", 32'(inst_valid_o), 32'd0);
    check_eq("rst_fault", 32'(fault_o), 32'd0);
    check_eq("rst_inst", inst_o, Nop);
    check_eq("rst_inst_pc", inst_pc_o, 32'h0);
    check_eq("rst_addr", imem_addr_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic check_drained(input string tag);
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    // Zero-wait streaming from reset.
    mem_lat = 0;
    do_reset();
    check_eq("t1_req_pre", 32'(imem_req_o), 32'd0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    cycle(0, 0, 0);
    check_eq("t1_req", 32'(imem_req_o), 32'd1);
    check_eq("t1_addr", imem_addr_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0);
      check_eq("t1_valid", 32'(inst_valid_o), 32'd1);
    end
    check_drained("t1_drained");

    // Slow memory and a stalled decode.
    mem_lat = 2;
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    cycle(0, 0, 0);
    check_eq("t2_addr_a", imem_addr_o, 32'h0);
    cycle(0, 0, 0);
    check_eq("t2_addr_b", imem_addr_o, 32'h0);
    cycle(1, 0, 0);
    check_eq("t2_addr_c", imem_addr_o, 32'h0);
    check_eq("t2_req_c", 32'(imem_req_o), 32'd1);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0);
      check_eq("t2_hold_req", 32'(imem_req_o), 32'd0);
      check_eq("t2_hold_valid", 32'(inst_valid_o), 32'd1);
      check_eq("t2_hold_pc", inst_pc_o, 32'h0);
      check_eq("t2_hold_inst", inst_o, mem_word(32'h0));
    end
    cycle(0, 0, 0);
    check_eq("t2_consume_req", 32'(imem_req_o), 32'd0);
    cycle(0, 0, 0);
    check_eq("t2_next_req", 32'(imem_req_o), 32'd1);
    check_eq("t2_next_addr", imem_addr_o, 32'h4);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    check_drained("t2_drained");

    // Redirect while a request is outstanding.
    mem_lat = 0;
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h100);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    mem_lat = 2;
    cycle(1, 0, 0);
    check_eq("t3_addr", imem_addr_o, 32'h8);
    check_eq("t3_valid_pre", 32'(inst_valid_o), 32'd1);
    cycle(1, 1, 32'h100);
    cycle(0, 0, 0);
    check_eq("t3_valid_drop", 32'(inst_valid_o), 32'd0);
    check_eq("t3_drain_req", 32'(imem_req_o), 32'd1);
    check_eq("t3_drain_addr", imem_addr_o, 32'h8);
    cycle(0, 0, 0);
    check_eq("t3_new_addr", imem_addr_o, 32'h100);
    check_eq("t3_no_fill", 32'(inst_valid_o), 32'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    check_drained("t3_drained");

    // Redirect in the same cycle as an ack.
    mem_lat = 0;
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h200);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    cycle(0, 1, 32'h200);
    check_eq("t4_addr_c", imem_addr_o, 32'hC);
    cycle(0, 0, 0);
    check_eq("t4_addr_new", imem_addr_o, 32'h200);
    check_eq("t4_no_fill", 32'(inst_valid_o), 32'd0);
    cycle(0, 0, 0);
    check_drained("t4_drained");

    // Misaligned redirect faults and halts until reset.
    mem_lat = 2;
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 1, 32'h102);
    check_eq("t5_fault_pre", 32'(fault_o), 32'd0);
    cycle(0, 0, 0);
    check_eq("t5_fault", 32'(fault_o), 32'd1);
    check_eq("t5_hold_req", 32'(imem_req_o), 32'd1);
    check_eq("t5_hold_addr", imem_addr_o, 32'h0);
    cycle(0, 1, 32'h300);
    check_eq("t5_halt_req", 32'(imem_req_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0);
      check_eq("t5_halt_req_n", 32'(imem_req_o), 32'd0);
      check_eq("t5_fault_sticky", 32'(fault_o), 32'd1);
      check_eq("t5_halt_valid", 32'(inst_valid_o), 32'd0);
    end
    check_drained("t5_drained");
    do_reset();
    cycle(0, 0, 0);
    check_eq("t5_restart_req", 32'(imem_req_o), 32'd1);
    check_eq("t5_restart_addr", imem_addr_o, 32'h0);

    // PC wraps past the top of the address space.
    mem_lat = 0;
    do_reset();
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    cycle(0, 1, 32'hFFFF_FFFC);
    check_eq("t6_addr_a", imem_addr_o, 32'h0);
    cycle(0, 0, 0);
    check_eq("t6_addr_b", imem_addr_o, 32'hFFFF_FFFC);
    cycle(0, 0, 0);
    check_eq("t6_addr_wrap", imem_addr_o, 32'h0);
    cycle(0, 0, 0);
    check_drained("t6_drained");

    // Reset while a request is live.
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
